// File: rtl/alu_resp_tx.sv
// alu_resp_tx
// Frames one ALU result word into a byte-stream response packet and drives it
// out on an AXI-Stream byte interface toward uart_tx.
//   Packet: HDR (RespHeader), LEN_L, LEN_H, then DataWidth/8 data bytes LSB
//   first, optionally followed by an XOR checksum byte.
// Optional feature macro: ALU_RESP_CHECKSUM_EN (appends the CSUM byte).
// Ports:
//   clk_i            system clock
//   rst_ni           synchronous active-low reset
//   s_data_i         ALU result to send
//   s_valid_i        result valid
//   s_ready_o        block can accept a result (IDLE only)
//   m_axis_tdata_o   byte to uart_tx (registered, stable until accepted)
//   m_axis_tvalid_o  byte valid (high for the whole packet)
//   m_axis_tready_i  uart_tx accepts byte
//   busy_o           packet in flight
//   pkt_count_o      completed packets, wraps FFFF->0000
module alu_resp_tx #(
  parameter int          DataWidth  = 32,
  parameter logic [7:0]  RespHeader = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] s_data_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic [7:0]           m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 busy_o,
  output logic [15:0]          pkt_count_o
);

  localparam int          NumBytes = DataWidth / 8;
  localparam logic [15:0] LenVal   = 16'(NumBytes);
  localparam logic [7:0]  LastIdx  = 8'(NumBytes - 1);

  if ((DataWidth % 8) != 0 || DataWidth < 8 || DataWidth > 2040) begin : g_param_check
    $error("alu_resp_tx: DataWidth must be a multiple of 8 in 8..2040");
  end

`ifdef ALU_RESP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, LEN_L, LEN_H, DATA, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, LEN_L, LEN_H, DATA} state_t;
`endif

  state_t               state_r;
  state_t               state_s;
  logic [DataWidth-1:0] shift_r;
  logic [7:0]           idx_r;
  logic [7:0]           tdata_r;
  logic                 valid_r;
  logic                 ready_r;
  logic [15:0]          pkt_count_r;
  logic                 hs_s;
  logic                 cap_s;
`ifdef ALU_RESP_CHECKSUM_EN
  logic [7:0]           csum_r;
`endif

  assign s_ready_o       = ready_r;
  assign m_axis_tdata_o  = tdata_r;
  assign m_axis_tvalid_o = valid_r;
  assign busy_o          = valid_r;
  assign pkt_count_o     = pkt_count_r;

  // Next-state logic; a byte only advances on a tvalid&tready handshake.
  always_comb begin
    state_s = state_r;
    hs_s    = valid_r && m_axis_tready_i;
    cap_s   = (state_r == IDLE) && s_valid_i && ready_r;
    case (state_r)
      IDLE:    if (cap_s) state_s = HDR;   else state_s = IDLE;
      HDR:     if (hs_s)  state_s = LEN_L; else state_s = HDR;
      LEN_L:   if (hs_s)  state_s = LEN_H; else state_s = LEN_L;
      LEN_H:   if (hs_s)  state_s = DATA;  else state_s = LEN_H;
      DATA: begin
        if (hs_s && idx_r == LastIdx) begin
`ifdef ALU_RESP_CHECKSUM_EN
          state_s = CSUM;
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = DATA;
        end
      end
`ifdef ALU_RESP_CHECKSUM_EN
      CSUM:    if (hs_s)  state_s = IDLE;  else state_s = CSUM;
`endif
      default: state_s = IDLE;
    endcase
  end

  // State register plus datapath: capture, byte sequencing, checksum, counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      idx_r       <= 8'h00;
      tdata_r     <= 8'h00;
      valid_r     <= 1'b0;
      ready_r     <= 1'b0;
      pkt_count_r <= 16'h0000;
`ifdef ALU_RESP_CHECKSUM_EN
      csum_r      <= 8'h00;
`endif
    end else begin
      state_r <= state_s;
      // Ready/valid are registered copies of the next state's decode.
      ready_r <= (state_s == IDLE);
      valid_r <= (state_s != IDLE);
`ifdef ALU_RESP_CHECKSUM_EN
      // Running XOR of every byte already accepted in this packet.
      if (state_r == IDLE) csum_r <= 8'h00;
      else if (hs_s)       csum_r <= csum_r ^ tdata_r;
`endif
      case (state_r)
        IDLE: begin
          if (cap_s) begin
            shift_r <= s_data_i;
            tdata_r <= RespHeader;
            idx_r   <= 8'h00;
          end
        end
        HDR:   if (hs_s) tdata_r <= LenVal[7:0];
        LEN_L: if (hs_s) tdata_r <= LenVal[15:8];
        LEN_H: begin
          if (hs_s) begin
            tdata_r <= shift_r[7:0];
            shift_r <= shift_r >> 8;
            idx_r   <= 8'h00;
          end
        end
        DATA: begin
          if (hs_s) begin
            if (idx_r == LastIdx) begin
`ifdef ALU_RESP_CHECKSUM_EN
              // csum_r lacks the byte being accepted now, so fold it in here.
              tdata_r <= csum_r ^ tdata_r;
`else
              tdata_r     <= 8'h00;
              pkt_count_r <= pkt_count_r + 16'd1;
`endif
            end else begin
              tdata_r <= shift_r[7:0];
              shift_r <= shift_r >> 8;
              idx_r   <= idx_r + 8'd1;
            end
          end
        end
`ifdef ALU_RESP_CHECKSUM_EN
        CSUM: begin
          if (hs_s) begin
            tdata_r     <= 8'h00;
            pkt_count_r <= pkt_count_r + 16'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
